// File: rtl/mem_access_stage_if.sv
// Data-bus port bundle for mem_access_stage: req/ack handshake, word address, byte lanes.
// The stage is the master; memory or interconnect is the slave.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_sel;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: big-endian byte lanes, alignment check, bus watchdog; MEM_LLSC_EN adds LL/SC.
// Latency: non-memory and error paths 0 cycles; memory ops finish in the bus_ack cycle or abort after TIMEOUT.
// Backpressure: stall_o holds upstream while a bus access is outstanding; the bus itself is req/ack.
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic              llbit_clr_i,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_o,
    output logic              align_err_o,
    output logic              bus_err_o,
    mem_access_stage_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e            state, next_state;
    logic [CNT_W-1:0]  cnt;
    size_e             size;
    logic              is_mem, is_load, is_signed, is_sc;
    logic              misaligned, sc_fail, op_done;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       load_data, lane_wdata;
    logic [3:0]        lane_sel;
    logic              b_req, b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [3:0]        b_sel;
    logic [31:0]       b_wdata;

    always_comb begin
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_signed = 1'b0;
        is_sc     = 1'b0;
        size      = SZ_W;
        case (mem_op_i)
            4'd1:    begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; size = SZ_B; end
            4'd2:    begin is_mem = 1'b1; is_load = 1'b1; size = SZ_B; end
            4'd3:    begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; size = SZ_H; end
            4'd4:    begin is_mem = 1'b1; is_load = 1'b1; size = SZ_H; end
            4'd5:    begin is_mem = 1'b1; is_load = 1'b1; end
            4'd6:    begin is_mem = 1'b1; size = SZ_B; end
            4'd7:    begin is_mem = 1'b1; size = SZ_H; end
            4'd8:    begin is_mem = 1'b1; end
`ifdef MEM_LLSC_EN
            4'd9:    begin is_mem = 1'b1; is_load = 1'b1; end
            4'd10:   begin is_mem = 1'b1; is_sc = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign misaligned = is_mem && ((size == SZ_H && mem_addr_i[0]) ||
                                   (size == SZ_W && mem_addr_i[1:0] != 2'b00));

`ifdef MEM_LLSC_EN
    logic llbit;

    // A clear from an exception/ERET wins over an LL completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)                          llbit <= 1'b0;
        else if (llbit_clr_i)             llbit <= 1'b0;
        else if (op_done && mem_op_i == 4'd9) llbit <= 1'b1;
        else if (op_done && is_sc)        llbit <= 1'b0;
    end

    assign sc_fail = is_sc && !llbit;
`else
    logic unused_llbit_clr;
    assign unused_llbit_clr = llbit_clr_i;
    assign sc_fail          = 1'b0;
`endif

    // Big-endian: byte offset 0 lives in bits 31:24.
    always_comb begin
        rbyte      = bus.bus_rdata[7:0];
        lane_sel   = 4'b1111;
        lane_wdata = mem_wdata_i;
        case (mem_addr_i[1:0])
            2'd0:    rbyte = bus.bus_rdata[31:24];
            2'd1:    rbyte = bus.bus_rdata[23:16];
            2'd2:    rbyte = bus.bus_rdata[15:8];
            default: rbyte = bus.bus_rdata[7:0];
        endcase
        rhalf = mem_addr_i[1] ? bus.bus_rdata[15:0] : bus.bus_rdata[31:16];
        case (size)
            SZ_B: begin
                load_data  = {{24{is_signed & rbyte[7]}}, rbyte};
                lane_sel   = 4'b1000 >> mem_addr_i[1:0];
                lane_wdata = {4{mem_wdata_i[7:0]}};
            end
            SZ_H: begin
                load_data  = {{16{is_signed & rhalf[15]}}, rhalf};
                lane_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: load_data = bus.bus_rdata;
        endcase
    end

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_o     = 1'b0;
        align_err_o = 1'b0;
        bus_err_o   = 1'b0;
        op_done     = 1'b0;
        next_state  = IDLE;
        b_req       = 1'b0;
        b_we        = 1'b0;
        b_addr      = '0;
        b_sel       = '0;
        b_wdata     = '0;
        if (rst) begin
            wd_o    = '0;
            wreg_o  = 1'b0;
            wdata_o = '0;
        end else if (is_mem) begin
            if (misaligned) begin
                align_err_o = 1'b1;
                wreg_o      = 1'b0;
            end else if (sc_fail) begin
                wdata_o = '0;
            end else if (state == WAIT && !bus.bus_ack && cnt == CNT_W'(TIMEOUT - 1)) begin
                bus_err_o = 1'b1;
                wreg_o    = 1'b0;
            end else begin
                b_req   = 1'b1;
                b_we    = !is_load;
                b_addr  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                b_sel   = lane_sel;
                b_wdata = lane_wdata;
                if (bus.bus_ack) begin
                    op_done = 1'b1;
                    if (is_load)    wdata_o = load_data;
                    else if (is_sc) wdata_o = 32'd1;
                    else            wreg_o  = 1'b0;
                end else begin
                    stall_o    = 1'b1;
                    wreg_o     = 1'b0;
                    next_state = WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (state == WAIT && next_state == WAIT) ? cnt + CNT_W'(1) : '0;
        end
    end

    assign bus.bus_req   = b_req;
    assign bus.bus_we    = b_we;
    assign bus.bus_addr  = b_addr;
    assign bus.bus_sel   = b_sel;
    assign bus.bus_wdata = b_wdata;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4); LL/SC scenarios follow MEM_LLSC_EN.
module tb_mem_access_stage;
    localparam logic [3:0] OP_NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8, LL = 4'd9, SC = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wd_i = 5'd7;
    logic        wreg_i = 1'b1;
    logic [31:0] wdata_i = 32'h1111_2222;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        llbit_clr_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o, stall_o, align_err_o, bus_err_o;
    logic [31:0] wdata_o;
    int          passed = 0;
    int          total = 0;

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .llbit_clr_i(llbit_clr_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_o(stall_o),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o),
        .bus(bus)
    );

    always #5 clk = ~clk;

    wire [110:0] all_outs = {wd_o, wreg_o, wdata_o, stall_o, align_err_o, bus_err_o,
                             bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_sel, bus.bus_wdata};

    logic [3:0]  ld_op   [8] = '{LB, LBU, LH, LHU, LB, LBU, LW, LH};
    logic [31:0] ld_addr [8] = '{32'h13, 32'h13, 32'h22, 32'h20, 32'h10, 32'h11, 32'h14, 32'h22};
    logic [31:0] ld_rd   [8] = '{32'h1234_5680, 32'h1234_5680, 32'h1234_F680, 32'h8001_F680,
                                 32'h8234_5678, 32'h8234_5678, 32'hDEAD_BEEF, 32'h0000_7FFF};
    logic [3:0]  ld_sel  [8] = '{4'b0001, 4'b0001, 4'b0011, 4'b1100, 4'b1000, 4'b0100, 4'b1111, 4'b0011};
    logic [31:0] ld_exp  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_F680, 32'h0000_8001,
                                 32'hFFFF_FF82, 32'h0000_0034, 32'hDEAD_BEEF, 32'h0000_7FFF};
    logic [3:0]  al_op   [5] = '{LW, LH, SW, SH, LHU};
    logic [31:0] al_addr [5] = '{32'h05, 32'h21, 32'h06, 32'h23, 32'h03};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdat,
                         input logic ack, input logic [31:0] rdat);
        mem_op_i      = op;
        mem_addr_i    = addr;
        mem_wdata_i   = sdat;
        bus.bus_ack   = ack;
        bus.bus_rdata = rdat;
        #4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(LW, 32'h10, 32'h0, 1'b0, 32'h0);
        total++; if (all_outs !== '0) $display("FAIL reset_mem_op: got %h expected 0", all_outs); else passed++;
        cyc();
        wdata_i = 32'h55;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        total++; if (all_outs !== '0) $display("FAIL reset_none_op: got %h expected 0", all_outs); else passed++;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        wdata_i = 32'h55;
        drive(OP_NONE, 32'h44, 32'h0, 1'b0, 32'h0);
        total++;
        if ({wd_o, wreg_o, wdata_o, stall_o, bus.bus_req, align_err_o} !== {5'd7, 1'b1, 32'h55, 3'b000})
            $display("FAIL none_pass: got %h/%b/%h stall %b req %b", wd_o, wreg_o, wdata_o, stall_o, bus.bus_req);
        else passed++;
        cyc();
        wdata_i = 32'hA5A5_0F0F;
        drive(4'd12, 32'h44, 32'h0, 1'b0, 32'h0);
        total++;
        if ({wdata_o, wreg_o, stall_o, bus.bus_req} !== {32'hA5A5_0F0F, 1'b1, 2'b00})
            $display("FAIL op12_as_none: got %h wreg %b stall %b req %b", wdata_o, wreg_o, stall_o, bus.bus_req);
        else passed++;
    endtask

    task automatic test_loads();
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(ld_op[i], ld_addr[i], 32'h0, 1'b1, ld_rd[i]);
            total++;
            if ({bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_addr} !== {1'b1, 1'b0, ld_sel[i], ld_addr[i] & 32'hFFFF_FFFC})
                $display("FAIL load_bus[%0d]: got req %b we %b sel %b addr %h expected sel %b",
                         i, bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_addr, ld_sel[i]);
            else passed++;
            total++;
            if ({wdata_o, wreg_o, stall_o} !== {ld_exp[i], 1'b1, 1'b0})
                $display("FAIL load_data[%0d]: got %h wreg %b stall %b expected %h", i, wdata_o, wreg_o, stall_o, ld_exp[i]);
            else passed++;
        end
    endtask

    task automatic test_store_wait();
        cyc();
        drive(SB, 32'h31, 32'hFFFF_FF5A, 1'b1, 32'h0);
        total++;
        if ({bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_wdata, wreg_o, stall_o} !== {2'b11, 4'b0100, 32'h5A5A_5A5A, 2'b00})
            $display("FAIL sb_zero_wait: got sel %b wdata %h wreg %b stall %b", bus.bus_sel, bus.bus_wdata, wreg_o, stall_o);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            cyc();
            drive(SH, 32'h22, 32'h1234_ABCD, c == 3, 32'h0);
            total++;
            if ({bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_addr, bus.bus_wdata} !== {2'b11, 4'b0011, 32'h20, 32'hABCD_ABCD})
                $display("FAIL sh_bus[%0d]: got sel %b addr %h wdata %h", c, bus.bus_sel, bus.bus_addr, bus.bus_wdata);
            else passed++;
            total++;
            if ({stall_o, wreg_o} !== {c < 3, 1'b0})
                $display("FAIL sh_stall[%0d]: got stall %b wreg %b expected stall %b", c, stall_o, wreg_o, c < 3);
            else passed++;
        end
        cyc();
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        total++; if (stall_o !== 1'b0) $display("FAIL sh_idle_after: got stall %b expected 0", stall_o); else passed++;
    endtask

    task automatic test_align();
        for (int i = 0; i < 5; i++) begin
            cyc();
            drive(al_op[i], al_addr[i], 32'hFFFF_FFFF, 1'b0, 32'h0);
            total++;
            if ({align_err_o, bus.bus_req, wreg_o, stall_o, bus_err_o} !== 5'b10000)
                $display("FAIL align[%0d]: got err %b req %b wreg %b stall %b expected 10000",
                         i, align_err_o, bus.bus_req, wreg_o, stall_o);
            else passed++;
        end
        cyc();
        drive(LB, 32'h23, 32'h0, 1'b1, 32'h0000_00FF);
        total++;
        if ({align_err_o, bus.bus_req, wdata_o} !== {2'b01, 32'hFFFF_FFFF})
            $display("FAIL align_lb_ok: got err %b req %b data %h", align_err_o, bus.bus_req, wdata_o);
        else passed++;
    endtask

    task automatic test_timeout();
        wdata_i = 32'h0000_0777;
        for (int c = 0; c < 4; c++) begin
            cyc();
            drive(SW, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
            total++;
            if ({stall_o, bus.bus_req, bus_err_o} !== 3'b110)
                $display("FAIL to_wait[%0d]: got stall %b req %b err %b expected 110", c, stall_o, bus.bus_req, bus_err_o);
            else passed++;
        end
        cyc();
        drive(SW, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
        total++;
        if ({stall_o, bus.bus_req, bus_err_o, wreg_o} !== 4'b0010)
            $display("FAIL to_abort: got stall %b req %b err %b wreg %b expected 0010", stall_o, bus.bus_req, bus_err_o, wreg_o);
        else passed++;
        cyc();
        drive(OP_NONE, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        total++;
        if ({stall_o, bus.bus_req, bus_err_o, wreg_o, wdata_o} !== {4'b0001, 32'h0000_0777})
            $display("FAIL to_late_ack: got stall %b req %b err %b data %h", stall_o, bus.bus_req, bus_err_o, wdata_o);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        for (int c = 0; c < 2; c++) begin
            cyc();
            drive(LW, 32'h80, 32'h0, 1'b0, 32'h0);
            total++; if (stall_o !== 1'b1) $display("FAIL rw_stall[%0d]: got %b expected 1", c, stall_o); else passed++;
        end
        cyc();
        rst = 1'b1;
        drive(LW, 32'h80, 32'h0, 1'b0, 32'h0);
        total++; if (all_outs !== '0) $display("FAIL rw_outs_zero: got %h expected 0", all_outs); else passed++;
        cyc();
        rst = 1'b0;
        wdata_i = 32'h55;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        total++;
        if ({wdata_o, wreg_o, stall_o, bus_err_o} !== {32'h55, 1'b1, 2'b00})
            $display("FAIL rw_none_after: got %h wreg %b stall %b err %b", wdata_o, wreg_o, stall_o, bus_err_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        cyc();
        drive(LW, 32'h10, 32'h0, 1'b0, 32'h0);
        total++; if (stall_o !== 1'b1) $display("FAIL b2b_stall: got %b expected 1", stall_o); else passed++;
        cyc();
        drive(LW, 32'h10, 32'h0, 1'b1, 32'h1122_3344);
        total++;
        if ({wdata_o, stall_o} !== {32'h1122_3344, 1'b0})
            $display("FAIL b2b_lw: got %h stall %b expected 11223344 0", wdata_o, stall_o);
        else passed++;
        cyc();
        drive(LBU, 32'h11, 32'h0, 1'b1, 32'hAABB_CCDD);
        total++;
        if ({bus.bus_req, wdata_o, stall_o} !== {1'b1, 32'h0000_00BB, 1'b0})
            $display("FAIL b2b_lbu: got req %b data %h stall %b expected 1 000000bb 0", bus.bus_req, wdata_o, stall_o);
        else passed++;
        cyc();
        drive(SW, 32'h18, 32'h0102_0304, 1'b0, 32'h0);
        total++;
        if ({bus.bus_req, bus.bus_we, stall_o} !== 3'b111)
            $display("FAIL b2b_sw_issue: got req %b we %b stall %b expected 111", bus.bus_req, bus.bus_we, stall_o);
        else passed++;
        cyc();
        drive(SW, 32'h18, 32'h0102_0304, 1'b1, 32'h0);
        total++; if ({stall_o, wreg_o} !== 2'b00) $display("FAIL b2b_sw_done: got stall %b wreg %b", stall_o, wreg_o); else passed++;
    endtask

    task automatic test_llsc();
`ifdef MEM_LLSC_EN
        cyc();
        drive(LL, 32'h100, 32'h0, 1'b1, 32'hCAFE_0000);
        total++;
        if ({wdata_o, wreg_o, bus.bus_we, stall_o} !== {32'hCAFE_0000, 3'b100})
            $display("FAIL ll_load: got %h wreg %b we %b stall %b", wdata_o, wreg_o, bus.bus_we, stall_o);
        else passed++;
        cyc();
        drive(SC, 32'h100, 32'h7, 1'b1, 32'h0);
        total++;
        if ({bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_wdata, wdata_o, wreg_o} !== {2'b11, 4'b1111, 32'h7, 32'h1, 1'b1})
            $display("FAIL sc_success: got req %b we %b wdata %h result %h wreg %b",
                     bus.bus_req, bus.bus_we, bus.bus_wdata, wdata_o, wreg_o);
        else passed++;
        cyc();
        drive(SC, 32'h100, 32'h7, 1'b1, 32'h0);
        total++;
        if ({bus.bus_req, wdata_o, wreg_o, stall_o} !== {1'b0, 32'h0, 2'b10})
            $display("FAIL sc_after_sc: got req %b result %h wreg %b stall %b", bus.bus_req, wdata_o, wreg_o, stall_o);
        else passed++;
        cyc();
        drive(LL, 32'h100, 32'h0, 1'b1, 32'h0);
        cyc();
        llbit_clr_i = 1'b1;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc();
        llbit_clr_i = 1'b0;
        drive(SC, 32'h100, 32'h9, 1'b1, 32'h0);
        total++;
        if ({bus.bus_req, wdata_o} !== {1'b0, 32'h0})
            $display("FAIL sc_after_clr: got req %b result %h expected 0 0", bus.bus_req, wdata_o);
        else passed++;
        cyc();
        llbit_clr_i = 1'b1;
        drive(LL, 32'h100, 32'h0, 1'b1, 32'h0);
        cyc();
        llbit_clr_i = 1'b0;
        drive(SC, 32'h100, 32'h9, 1'b1, 32'h0);
        total++;
        if ({bus.bus_req, wdata_o} !== {1'b0, 32'h0})
            $display("FAIL sc_clr_beats_ll: got req %b result %h expected 0 0", bus.bus_req, wdata_o);
        else passed++;
`else
        cyc();
        wdata_i = 32'h0BAD_F00D;
        drive(LL, 32'h100, 32'h0, 1'b1, 32'hCAFE_0000);
        total++;
        if ({bus.bus_req, stall_o, wreg_o, wdata_o} !== {3'b001, 32'h0BAD_F00D})
            $display("FAIL ll_as_none: got req %b stall %b wreg %b data %h", bus.bus_req, stall_o, wreg_o, wdata_o);
        else passed++;
        cyc();
        drive(SC, 32'h100, 32'h7, 1'b1, 32'h0);
        total++;
        if ({bus.bus_req, stall_o, wreg_o, wdata_o} !== {3'b001, 32'h0BAD_F00D})
            $display("FAIL sc_as_none: got req %b stall %b wreg %b data %h", bus.bus_req, stall_o, wreg_o, wdata_o);
        else passed++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = '0;
        test_reset();
        test_passthrough();
        test_loads();
        test_store_wait();
        test_align();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_llsc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised successor to the pipeline's memory stage. Sits between EX/MEM and MEM/WB. Passes non-memory results straight through with zero latency. Executes loads and stores on a req/ack data bus: byte lanes, sign/zero extension, misalignment detection and a bus-timeout watchdog. Stalls the pipeline while an access is outstanding.

## Interface
- ADDR_W, 32, data-bus address width
- REG_AW, 5, register-file address width
- TIMEOUT, 16, maximum WAIT cycles without bus_ack before abort (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wd_i / wreg_i / wdata_i  in  REG_AW / 1 / 32  destination, write enable, ALU result from EX
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 treated as NONE
- mem_addr_i  in  ADDR_W  effective address
- mem_wdata_i  in  32  store data (right-justified)
- llbit_clr_i  in  1  clear LL reservation (exception/ERET)
- wd_o / wreg_o / wdata_o  out  REG_AW / 1 / 32  to MEM/WB
- stall_o  out  1  hold EX/MEM and earlier stages
- align_err_o / bus_err_o  out  1 / 1  single-cycle error pulses
- bus_req / bus_we  out  1 / 1  bus request, write
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- bus_sel  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  access complete
- bus_rdata  in  32  read data, valid with bus_ack

## Operation
- Big-endian lanes: addr[1:0]=0 → bits 31:24 (sel 1000), 3 → bits 7:0 (sel 0001). Halfword addr[1]=0 → sel 1100. Word → sel 1111.
- Store data replicated: SB {4{b}}, SH {2{h}}.
- Loads: the selected byte/half is sign-extended (LB, LH) or zero-extended (LBU, LHU). LW/LL pass the word through.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW/LL/SC need addr[1:0]=0.
  - On violation: no bus access, align_err_o=1, wreg_o=0, stall_o=0.
- NONE: wd_o/wreg_o/wdata_o = inputs, combinationally, same cycle.
- FSM states: IDLE, WAIT.
  - IDLE with an aligned memory op: bus_req=1 with address/sel/we/wdata.
    - bus_ack same cycle (zero-wait): op completes, stay IDLE.
    - Otherwise go to WAIT; counter cleared; stall_o=1.
  - WAIT: bus_req and all bus outputs held stable from the inputs; the upstream holds its inputs while stall_o=1. counter increments each cycle.
    - bus_ack: op completes, go to IDLE.
    - No ack with counter==TIMEOUT-1: abort. bus_req=0, bus_err_o=1, wreg_o=0, stall_o=0, go to IDLE. A late ack after abort is ignored.
- Completion cycle: stall_o=0.
  - Load: wreg_o=wreg_i, wdata_o=formatted bus_rdata.
  - Store: wreg_o=0.
- stall_o = memory op in progress AND NOT (bus_ack OR abort).

## Timing
- Non-memory and error paths: 0-cycle latency, combinational.
- Memory op with ack N cycles after request (N=0 zero-wait): stall_o high for N cycles; result on cycle N.
- Timeout: request cycle 0, abort on cycle TIMEOUT; stall_o high for cycles 0..TIMEOUT-1.
- Reset: while rst=1 all outputs are 0 (wd_o, wreg_o, wdata_o, stall_o, errors, bus_*). The next edge forces IDLE, counter 0 and LLbit 0. Reset mid-WAIT abandons the access without an error pulse.
- Back-to-back memory ops: the next op issues in the cycle after completion.

## Configuration
- MEM_LLSC_EN defined:
  - LL completes as LW and sets LLbit at that edge.
  - SC with LLbit=1 performs SW, then writes wdata_o=1 and clears LLbit.
  - SC with LLbit=0 makes no bus access; wdata_o=0, wreg_o=wreg_i, 0-cycle latency.
  - llbit_clr_i clears LLbit at the edge; it takes priority over an LL set in the same cycle.
- MEM_LLSC_EN undefined: LL and SC are treated as NONE. No LLbit register; llbit_clr_i is ignored.

## Test plan
- LB at addr 0x13, bus_rdata=0x1234_5680, ack same cycle → bus_sel=0001, wdata_o=0xFFFF_FF80, stall_o never high. LBU → 0x0000_0080.
- SH data 0xABCD at 0x22, ack after 3 cycles → bus_sel=0011, bus_wdata=0xABCD_ABCD, stall_o high 3 cycles, wreg_o=0 at completion.
- LW at 0x05 → align_err_o=1 for one cycle, bus_req=0, wreg_o=0, stall_o=0.
- TIMEOUT=4, SW, never ack → stall_o high cycles 0-3, bus_err_o=1 on cycle 4, IDLE on cycle 5.
- rst asserted during WAIT of an LW → all outputs 0; after release a NONE op passes wdata_i=0x55 through the same cycle.
- MEM_LLSC_EN: LL 0x100 then SC 0x100 → store issued, wdata_o=1. LL, llbit_clr_i pulse, SC → no bus_req, wdata_o=0.
